// File: rtl/acc_stack_pkg.sv
// acc_stack_pkg: shared definitions for the accumulator spill stack.
//   CPU_WIDTH   - default data width, kept equal to the accumulator width
//   STACK_DEPTH - default number of stack entries
//   stack_op_e  - decoded request type for one cycle
//   decode_op   - maps the PUSH/POP request pair onto stack_op_e
package acc_stack_pkg;

  localparam int CPU_WIDTH   = 4;
  localparam int STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_XCHG = 2'd3
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    stack_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_XCHG;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/acc_stack_mem.sv
// stack_mem: DEPTH x WIDTH register array backing the accumulator stack.
//   clk        - write clock
//   we, waddr, wdata - synchronous write port
//   raddr, rdata     - asynchronous read port (driven with the top-of-stack index)
// The array has no reset; its contents are meaningless until written.
module stack_mem
  import acc_stack_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end else begin
      mem_q[waddr] <= mem_q[waddr];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/acc_stack.sv
// acc_stack: hardware LIFO for saving and restoring the accumulator.
//   CLK   - clock, all state changes on the rising edge
//   RST   - synchronous active-high reset, wins over PUSH/POP
//   PUSH  - store IN on top of the stack
//   POP   - remove the top entry and present it on OUT
//   IN    - data to push (accumulator output bus)
//   OUT   - registered popped data (accumulator load path)
//   VALID - one-cycle strobe, OUT was updated by a pop this edge
//   COUNT - number of stored entries, 0..DEPTH
//   EMPTY / FULL - decoded from COUNT
//   OVF / UNF    - sticky overflow / underflow flags, cleared only by RST
module acc_stack
  import acc_stack_pkg::*;
#(
  parameter int WIDTH  = CPU_WIDTH,
  parameter int DEPTH  = STACK_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID,
  output logic [CNT_W-1:0] COUNT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF,
  output logic             UNF
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             empty_s, full_s;
  logic [CNT_W-1:0] top_s;
  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [WIDTH-1:0] rdata_s;
  stack_op_e        op_s;

  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign full_s  = (count_q == CNT_W'(DEPTH));
  // Index of the current top entry; only used when the stack is not empty.
  assign top_s   = count_q - CNT_W'(1);
  assign op_s    = decode_op(PUSH, POP);

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (IN),
    .raddr (top_s[AW-1:0]),
    .rdata (rdata_s)
  );

  // Push/pop decode: next count, output, strobe, flags and memory write
  always_comb begin
    count_d = count_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we_s    = 1'b0;
    waddr_s = count_q[AW-1:0];
    case (op_s)
      OP_PUSH: begin
        if (full_s) begin
          ovf_d = 1'b1;
        end else begin
          we_s    = ~RST;
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty_s) begin
          unf_d = 1'b1;
        end else begin
          out_d   = rdata_s;
          valid_d = 1'b1;
          count_d = top_s;
        end
      end
      OP_XCHG: begin
        // Exchange swaps the top entry in place; on an empty stack the
        // incoming word goes straight to OUT without touching storage.
        valid_d = 1'b1;
        if (empty_s) begin
          out_d = IN;
        end else begin
          out_d   = rdata_s;
          we_s    = ~RST;
          waddr_s = top_s[AW-1:0];
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= {CNT_W{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign OUT   = out_q;
  assign VALID = valid_q;
  assign COUNT = count_q;
  assign EMPTY = empty_s;
  assign FULL  = full_s;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule

// File: tb/tb_acc_stack.sv
// tb_acc_stack: randomized and directed bench for acc_stack (WIDTH=4, DEPTH=4).
// The driver applies one request per cycle, advances a queue-based stack
// model and queues the expected status and popped data; a monitor on the
// falling edge compares the DUT against those queues.
module tb_acc_stack;

  localparam int W     = 4;
  localparam int D     = 4;
  localparam int CNT_W = $clog2(D) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [W-1:0]     din = '0;
  logic [W-1:0]     dout;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             empty, full, ovf, unf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cnt;
    bit emp;
    bit ful;
    bit ovf;
    bit unf;
    bit vld;
    int out;
  } stat_t;

  stat_t stat_q[$];
  int    data_q[$];

  // Reference model state
  int stk[$];
  int m_out = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  acc_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK   (clk),
    .RST   (rst),
    .PUSH  (push),
    .POP   (pop),
    .IN    (din),
    .OUT   (dout),
    .VALID (valid),
    .COUNT (count),
    .EMPTY (empty),
    .FULL  (full),
    .OVF   (ovf),
    .UNF   (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One request cycle: drive inputs, advance the model, queue expectations.
  task automatic step(input bit r, input bit pu, input bit po, input int d);
    bit vld;
    stat_t s;
    rst  = r;
    push = pu;
    pop  = po;
    din  = d[W-1:0];
    vld  = 1'b0;
    if (r) begin
      stk.delete();
      m_out = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (pu && po) begin
      vld = 1'b1;
      if (stk.size() == 0) begin
        m_out = d;
      end else begin
        m_out = stk[stk.size()-1];
        stk[stk.size()-1] = d;
      end
    end else if (pu) begin
      if (stk.size() == D) m_ovf = 1'b1;
      else stk.push_back(d);
    end else if (po) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else begin
        m_out = stk.pop_back();
        vld = 1'b1;
      end
    end
    if (vld) data_q.push_back(m_out);
    s.cnt = stk.size();
    s.emp = (stk.size() == 0);
    s.ful = (stk.size() == D);
    s.ovf = m_ovf;
    s.unf = m_unf;
    s.vld = vld;
    s.out = m_out;
    stat_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare status every cycle, popped data whenever VALID is seen
  always @(negedge clk) begin : mon
    stat_t s;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("count", int'(count), s.cnt);
      chk("empty", int'(empty), int'(s.emp));
      chk("full",  int'(full),  int'(s.ful));
      chk("ovf",   int'(ovf),   int'(s.ovf));
      chk("unf",   int'(unf),   int'(s.unf));
      chk("valid", int'(valid), int'(s.vld));
      chk("out_hold", int'(dout), s.out);
    end
    if (valid === 1'b1) begin
      if (data_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        chk("pop_data", int'(dout), data_q.pop_front());
      end
    end
  end

  initial begin
    // Reset wins over a simultaneous push
    step(1, 1, 0, 'hA);
    // LIFO order
    step(0, 1, 0, 'h5);
    step(0, 1, 0, 'hF);
    step(0, 1, 0, 'h0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    // Full and overflow; 9 must not be stored
    step(0, 1, 0, 1);
    step(0, 1, 0, 2);
    step(0, 1, 0, 3);
    step(0, 1, 0, 4);
    step(0, 1, 0, 'h9);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // Underflow
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 'h7);
    step(0, 0, 1, 0);
    // Exchange then bypass
    step(1, 0, 0, 0);
    step(0, 1, 0, 'h3);
    step(0, 1, 0, 'h6);
    step(0, 1, 1, 'hC);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 'hB);
    // Exchange while full
    step(0, 1, 0, 1);
    step(0, 1, 0, 2);
    step(0, 1, 0, 3);
    step(0, 1, 0, 4);
    step(0, 1, 1, 'hE);
    step(0, 0, 1, 0);
    // Reset during a pop, then underflow
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 2);
    step(0, 1, 0, 3);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 15));
    end
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk);
    #1;
    chk("stat_drain", stat_q.size(), 0);
    chk("data_drain", data_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
